// File: rtl/input_keypad_encoder_pkg.sv
// Shared definitions for the keypad command input path:
// command codes, key index width and encoder FSM states.
package input_keypad_encoder_pkg;

    localparam int IC_N     = 5;
    localparam int IK_IDX_W = 4;

    localparam logic [IC_N-1:0] IC_D0  = 5'h00;
    localparam logic [IC_N-1:0] IC_D1  = 5'h01;
    localparam logic [IC_N-1:0] IC_D2  = 5'h02;
    localparam logic [IC_N-1:0] IC_D3  = 5'h03;
    localparam logic [IC_N-1:0] IC_D4  = 5'h04;
    localparam logic [IC_N-1:0] IC_D5  = 5'h05;
    localparam logic [IC_N-1:0] IC_D6  = 5'h06;
    localparam logic [IC_N-1:0] IC_D7  = 5'h07;
    localparam logic [IC_N-1:0] IC_D8  = 5'h08;
    localparam logic [IC_N-1:0] IC_D9  = 5'h09;
    localparam logic [IC_N-1:0] IC_ADD = 5'h10;
    localparam logic [IC_N-1:0] IC_SUB = 5'h11;
    localparam logic [IC_N-1:0] IC_MUL = 5'h12;
    localparam logic [IC_N-1:0] IC_DIV = 5'h13;
    localparam logic [IC_N-1:0] IC_EQ  = 5'h14;
    localparam logic [IC_N-1:0] IC_CLR = 5'h15;

    typedef enum logic [1:0] {
        IK_SCAN,
        IK_DEBOUNCE,
        IK_PRESENT,
        IK_RELEASE
    } ik_state_e;

    // Highest set bit; only meaningful for a one-hot snapshot.
    function automatic logic [IK_IDX_W-1:0] ik_onehot_idx(
        input logic [15:0] v
    );
        logic [IK_IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = IK_IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/input_keypad_encoder_if.sv
// Command valid/ack handshake between keypad encoder
// (master) and controller (slave).
interface input_keypad_encoder_if;
    import input_keypad_encoder_pkg::*;

    logic [IC_N-1:0] in_cmd;
    logic            in_valid;
    logic            in_ack;

    modport master (
        output in_cmd,
        output in_valid,
        input  in_ack
    );

    modport slave (
        input  in_cmd,
        input  in_valid,
        output in_ack
    );

endinterface

// File: rtl/input_keypad_encoder_keymap.sv
// Combinational key index to command code map.
// Index is row*4+col of the 4x4 matrix.
module keypad_keymap
    import input_keypad_encoder_pkg::*;
(
    input  logic [IK_IDX_W-1:0] idx_i,
    output logic [IC_N-1:0]     code_o
);

    always_comb begin
        code_o = IC_D0;
        case (idx_i)
            4'd0:    code_o = IC_D0;
            4'd1:    code_o = IC_D1;
            4'd2:    code_o = IC_D2;
            4'd3:    code_o = IC_D3;
            4'd4:    code_o = IC_D4;
            4'd5:    code_o = IC_D5;
            4'd6:    code_o = IC_D6;
            4'd7:    code_o = IC_D7;
            4'd8:    code_o = IC_D8;
            4'd9:    code_o = IC_D9;
            4'd10:   code_o = IC_ADD;
            4'd11:   code_o = IC_SUB;
            4'd12:   code_o = IC_MUL;
            4'd13:   code_o = IC_DIV;
            4'd14:   code_o = IC_EQ;
            default: code_o = IC_CLR;
        endcase
    end

endmodule

// File: rtl/input_keypad_encoder.sv
// 4x4 keypad scanner, debouncer and command encoder.
// Optional auto-repeat: define INPUT_KEYPAD_REPEAT_EN.
module input_keypad_encoder
    import input_keypad_encoder_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEB_CNT  = 4
`ifdef INPUT_KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 500000
`endif
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [3:0]            row_n,
    input  logic [3:0]            col_n,
    input_keypad_encoder_if.master kif
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEB_CNT + 1);

    logic [3:0]          sync1_q, sync2_q;
    logic [SW-1:0]       div_q;
    logic [1:0]          row_q;
    logic [11:0]         snap_q;
    ik_state_e           state_q, state_d;
    logic [IK_IDX_W-1:0] idx_q, idx_d;
    logic [DW-1:0]       deb_q, deb_d;
    logic [IC_N-1:0]     cmd_q, cmd_d;
    logic                vld_q, vld_d;

    logic                smp, scan_done;
    logic [3:0]          pressed;
    logic [15:0]         snap;
    logic                hot, one, same;
    logic [IK_IDX_W-1:0] sidx;
    logic [IC_N-1:0]     map_code;

    assign smp       = (div_q == SW'(SCAN_DIV - 1));
    assign scan_done = smp && (row_q == 2'd3);
    assign pressed   = ~sync2_q;
    assign snap      = {pressed, snap_q};
    assign hot       = |snap;
    assign one       = hot && ((snap & (snap - 16'd1)) == 16'd0);
    assign sidx      = ik_onehot_idx(snap);
    assign same      = one && (sidx == idx_q);

    keypad_keymap u_keymap (
        .idx_i  (idx_q),
        .code_o (map_code)
    );

`ifdef INPUT_KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] rep_q, rep_d, rep_lim;
    logic          rpt_q, rpt_d;
    logic          hold_q, hold_d;

    // First repeat after the full hold time, then at quarter spacing.
    assign rep_lim = rpt_q ? RW'(REPEAT_CYCLES / 4 - 1)
                           : RW'(REPEAT_CYCLES - 1);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        deb_d   = deb_q;
        cmd_d   = cmd_q;
        vld_d   = vld_q;
`ifdef INPUT_KEYPAD_REPEAT_EN
        rep_d  = rep_q;
        rpt_d  = rpt_q;
        hold_d = scan_done ? same : hold_q;
`endif
        unique case (state_q)
            IK_SCAN: begin
                if (scan_done && one) begin
                    idx_d   = sidx;
                    deb_d   = DW'(1);
                    state_d = IK_DEBOUNCE;
                end
            end
            IK_DEBOUNCE: begin
                if (scan_done) begin
                    if (same) begin
                        deb_d = deb_q + DW'(1);
                        if (deb_d == DW'(DEB_CNT)) begin
                            cmd_d   = map_code;
                            vld_d   = 1'b1;
                            state_d = IK_PRESENT;
`ifdef INPUT_KEYPAD_REPEAT_EN
                            rpt_d = 1'b0;
`endif
                        end
                    end else begin
                        deb_d   = '0;
                        state_d = IK_SCAN;
                    end
                end
            end
            IK_PRESENT: begin
                if (kif.in_ack) begin
                    vld_d   = 1'b0;
                    deb_d   = '0;
                    state_d = IK_RELEASE;
`ifdef INPUT_KEYPAD_REPEAT_EN
                    rep_d = '0;
`endif
                end
            end
            IK_RELEASE: begin
                if (scan_done) begin
                    if (!hot) begin
                        deb_d = deb_q + DW'(1);
                        if (deb_d == DW'(DEB_CNT)) begin
                            deb_d   = '0;
                            state_d = IK_SCAN;
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
`ifdef INPUT_KEYPAD_REPEAT_EN
                if (scan_done && !same) begin
                    rep_d = '0;
                    rpt_d = 1'b0;
                end else if (hold_q) begin
                    rep_d = rep_q + RW'(1);
                    if (rep_q == rep_lim) begin
                        rep_d   = '0;
                        rpt_d   = 1'b1;
                        deb_d   = '0;
                        vld_d   = 1'b1;
                        state_d = IK_PRESENT;
                    end
                end
`endif
            end
            default: state_d = IK_SCAN;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            div_q   <= '0;
            row_q   <= '0;
            snap_q  <= '0;
            state_q <= IK_SCAN;
            idx_q   <= '0;
            deb_q   <= '0;
            cmd_q   <= '0;
            vld_q   <= 1'b0;
`ifdef INPUT_KEYPAD_REPEAT_EN
            rep_q  <= '0;
            rpt_q  <= 1'b0;
            hold_q <= 1'b0;
`endif
        end else begin
            sync1_q <= col_n;
            sync2_q <= sync1_q;
            div_q   <= smp ? '0 : div_q + SW'(1);
            if (smp) begin
                row_q <= row_q + 2'd1;
                case (row_q)
                    2'd0:    snap_q[3:0]  <= pressed;
                    2'd1:    snap_q[7:4]  <= pressed;
                    2'd2:    snap_q[11:8] <= pressed;
                    default: ;
                endcase
            end
            state_q <= state_d;
            idx_q   <= idx_d;
            deb_q   <= deb_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
`ifdef INPUT_KEYPAD_REPEAT_EN
            rep_q  <= rep_d;
            rpt_q  <= rpt_d;
            hold_q <= hold_d;
`endif
        end
    end

    assign row_n        = ~(4'b0001 << row_q);
    assign kif.in_cmd   = cmd_q;
    assign kif.in_valid = vld_q;

endmodule

// File: tb/tb_input_keypad_encoder.sv
// Self-checking bench for input_keypad_encoder:
// keymap table, directed corner cases and randomized key episodes.
module tb_input_keypad_encoder;

    localparam int SD   = 8;
    localparam int DC   = 4;
    localparam int RC   = 400;
    localparam int SCAN = 4 * SD;
    localparam int LAT  = (DC + 1) * SCAN + 1;
    localparam int REL  = (DC + 3) * SCAN;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keys = '0;

    logic [3:0]  km_idx = '0;
    logic [4:0]  km_code;

    int n_chk  = 0;
    int n_fail = 0;

    int          ack_mode = 0;
    int          vrise    = 0;
    int          stab_err = 0;
    logic        pv       = 1'b0;
    logic [4:0]  pc       = '0;
    logic [4:0]  xq[$];

    input_keypad_encoder_if kif ();

    input_keypad_encoder #(
        .SCAN_DIV (SD),
        .DEB_CNT  (DC)
`ifdef INPUT_KEYPAD_REPEAT_EN
        ,
        .REPEAT_CYCLES (RC)
`endif
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .row_n (row_n),
        .col_n (col_n),
        .kif   (kif)
    );

    keypad_keymap u_km (
        .idx_i  (km_idx),
        .code_o (km_code)
    );

    always #5 Clock = ~Clock;

    // Key matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
            end
        end
    end

    // Controller side: ack policy, then record the transfer the next edge takes.
    always @(negedge Clock) begin
        case (ack_mode)
            0:       kif.in_ack = 1'b0;
            1:       kif.in_ack = 1'b1;
            default: kif.in_ack = 1'($urandom_range(0, 1));
        endcase
        if (kif.in_valid && !pv) vrise++;
        if (kif.in_valid && pv && kif.in_cmd !== pc) stab_err++;
        pv = kif.in_valid;
        pc = kif.in_cmd;
        if (Reset && kif.in_valid && kif.in_ack) xq.push_back(kif.in_cmd);
    end

    typedef struct {
        logic [3:0] idx;
        logic [4:0] code;
    } km_vec_t;

    km_vec_t    kv[16];
    logic [4:0] expq[$];

    function automatic logic [4:0] ref_code(input int k);
        return (k < 10) ? 5'(k) : 5'(16 + k - 10);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int took);
        took = 0;
        while (!kif.in_valid && took < budget) begin
            cyc(1);
            took++;
        end
    endtask

    initial begin
        int took, vb, xb, bad, k, k2, typ, cnt;

        for (int i = 0; i < 10; i++) kv[i] = '{4'(i), 5'(i)};
        kv[10] = '{4'd10, 5'h10};
        kv[11] = '{4'd11, 5'h11};
        kv[12] = '{4'd12, 5'h12};
        kv[13] = '{4'd13, 5'h13};
        kv[14] = '{4'd14, 5'h14};
        kv[15] = '{4'd15, 5'h15};
        for (int i = 0; i < 16; i++) begin
            km_idx = kv[i].idx;
            #1;
            chk($sformatf("keymap%0d", i), km_code, kv[i].code);
        end

        // Reset with a key held
        Reset    = 1'b0;
        keys     = 16'h1 << 5;
        ack_mode = 1;
        vb = vrise;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("rst_row", row_n, 4'b1110);
            chk("rst_valid", kif.in_valid, 0);
        end
        chk("rst_cmd", kif.in_cmd, 0);
        keys = '0;
        cyc(2);
        Reset = 1'b1;
        cyc(SD);
        chk("row1", row_n, 4'b1101);
        cyc(SD);
        chk("row2", row_n, 4'b1011);
        cyc(6 * SCAN);
        chk("rst_noout", vrise - vb, 0);

        // Key 7 with ack tied high
        vb = vrise;
        xb = xq.size();
        keys = 16'h1 << 7;
        wait_valid(LAT + 2, took);
        chk("k7_valid", kif.in_valid, 1);
        chk("k7_latency_ok", int'(took <= LAT), 1);
        cyc(10 * SCAN);
        chk("k7_pulses", vrise - vb, 1);
        chk("k7_xfers", xq.size() - xb, 1);
        if (xq.size() > xb) chk("k7_code", xq[xb], 5'h07);
        keys = '0;
        cyc(REL);

        // Key A held with ack low, then one ack pulse
        ack_mode = 0;
        xb = xq.size();
        keys = 16'h1 << 10;
        wait_valid(LAT + 2, took);
        chk("A_valid", kif.in_valid, 1);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            if (!kif.in_valid || kif.in_cmd !== 5'h10) bad++;
        end
        chk("A_hold", bad, 0);
        ack_mode = 1;
        cyc(1);
        ack_mode = 0;
        chk("A_before_ack", kif.in_valid, 1);
        cyc(1);
        chk("A_clear", kif.in_valid, 0);
        chk("A_xfers", xq.size() - xb, 1);
        if (xq.size() > xb) chk("A_code", xq[xb], 5'h10);
        keys = '0;
        cyc(REL);

        // Bouncing key 3
        ack_mode = 1;
        vb = vrise;
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? (16'h1 << 3) : 16'h0;
            cyc(SCAN);
        end
        keys = '0;
        cyc(REL);
        chk("bounce_none", vrise - vb, 0);

        // Keys 1 and 2 together, then 2 released
        vb = vrise;
        xb = xq.size();
        keys = (16'h1 << 1) | (16'h1 << 2);
        cyc(8 * SCAN);
        chk("multi_none", vrise - vb, 0);
        keys = 16'h1 << 1;
        wait_valid(LAT + 2, took);
        chk("multi_then_1", kif.in_valid, 1);
        cyc(8 * SCAN);
        chk("k1_xfers", xq.size() - xb, 1);
        if (xq.size() > xb) chk("k1_code", xq[xb], 5'h01);
        keys = '0;
        cyc(REL);

        // Reset while a command is offered
        ack_mode = 0;
        keys = 16'h1 << 9;
        wait_valid(LAT + 2, took);
        chk("k9_valid", kif.in_valid, 1);
        Reset = 1'b0;
        keys  = '0;
        cyc(1);
        chk("midrst_valid", kif.in_valid, 0);
        chk("midrst_cmd", kif.in_cmd, 0);
        chk("midrst_row", row_n, 4'b1110);
        Reset = 1'b1;
        vb = vrise;
        cyc(REL);
        chk("midrst_nopend", vrise - vb, 0);

        // Key # held for 3*RC cycles with ack high
        ack_mode = 1;
        xb = xq.size();
        keys = 16'h1 << 15;
        cyc(3 * RC);
        keys = '0;
        cyc(REL);
        cnt = xq.size() - xb;
        bad = 0;
        for (int i = xb; i < xq.size(); i++) begin
            if (xq[i] !== 5'h15) bad++;
        end
        chk("hash_codes", bad, 0);
`ifdef INPUT_KEYPAD_REPEAT_EN
        chk("hash_repeats", int'(cnt >= 4), 1);
`else
        chk("hash_single", cnt, 1);
`endif

        // Randomized episodes against the reference model
        ack_mode = 2;
        xb = xq.size();
        for (int ep = 0; ep < 24; ep++) begin
            typ = $urandom_range(0, 2);
            k   = $urandom_range(0, 15);
            case (typ)
                0: begin
                    keys = 16'h1 << k;
                    cyc(REL);
                    expq.push_back(ref_code(k));
                end
                1: begin
                    keys = 16'h1 << k;
                    cyc($urandom_range(1, 40));
                end
                default: begin
                    k2 = (k + $urandom_range(1, 15)) % 16;
                    keys = (16'h1 << k) | (16'h1 << k2);
                    cyc(REL);
                end
            endcase
            keys = '0;
            cyc(REL);
        end
        chk("rnd_count", xq.size() - xb, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (xb + i < xq.size())
                chk($sformatf("rnd_code%0d", i), xq[xb+i], expq[i]);
        end

        chk("cmd_stable", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
